// File: rtl/lm32_ram_reader_pkg.sv
// Shared definitions for the lm32 RAM reader: FSM state encoding and skid depth.
package lm32_ram_reader_pkg;

    typedef enum logic [1:0] {
        RR_STATE_IDLE  = 2'd0,
        RR_STATE_RUN   = 2'd1,
        RR_STATE_DRAIN = 2'd2,
        RR_STATE_DONE  = 2'd3
    } rr_state_e;

    // Must stay a power of two: the FIFO pointers wrap by natural overflow.
    localparam int RR_FIFO_DEPTH = 2;

endpackage

// File: rtl/lm32_ram_reader_fifo.sv
// Small synchronous skid FIFO carrying a data word plus an end-of-burst flag.
module lm32_ram_reader_fifo
    import lm32_ram_reader_pkg::*;
#(
    parameter int data_width = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [data_width-1:0] push_data_i,
    input  logic                  push_last_i,
    input  logic                  pop_i,
    output logic [1:0]            count_o,
    output logic [data_width-1:0] data_o,
    output logic                  last_o
);

    localparam int ptr_w = $clog2(RR_FIFO_DEPTH);

    logic [data_width-1:0] data_q [RR_FIFO_DEPTH];
    logic                  last_q [RR_FIFO_DEPTH];
    logic [ptr_w-1:0]      wr_ptr_q;
    logic [ptr_w-1:0]      rd_ptr_q;
    logic [1:0]            count_q;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'(RR_FIFO_DEPTH)) || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: storage is reset because the head entry drives out_data, which must read 0 after reset.
            for (int i = 0; i < RR_FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                data_q[wr_ptr_q] <= push_data_i;
                last_q[wr_ptr_q] <= push_last_i;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign count_o = count_q;
    assign data_o  = data_q[rd_ptr_q];
    assign last_o  = last_q[rd_ptr_q];

endmodule

// File: rtl/lm32_ram_reader.sv
// Streams a contiguous range out of an lm32_ram read port onto a valid/ready stream,
// returning same-cycle writes coherently by snooping the RAM write port.
module lm32_ram_reader
    import lm32_ram_reader_pkg::*;
#(
    parameter int data_width    = 32,
    parameter int address_width = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start,
    input  logic [address_width-1:0] start_address,
    input  logic [address_width:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic                     enable_read,
    output logic [address_width-1:0] read_address,
    input  logic [data_width-1:0]    read_data,
    input  logic                     snoop_enable_write,
    input  logic                     snoop_write_enable,
    input  logic [address_width-1:0] snoop_write_address,
    input  logic [data_width-1:0]    snoop_write_data,
    output logic                     out_valid,
    output logic [data_width-1:0]    out_data,
    output logic                     out_last,
    input  logic                     out_ready
);

    rr_state_e                state_q, state_d;
    logic [address_width-1:0] addr_q, addr_d;
    logic [address_width:0]   remaining_q, remaining_d;
    logic                     inflight_q;
    logic                     inflight_last_q;
    logic                     snoop_hit_q;
    logic [data_width-1:0]    snoop_data_q;

    logic [1:0]               fifo_count;
    logic [data_width-1:0]    fifo_data;
    logic                     fifo_last;
    logic                     fifo_empty;
    logic [data_width-1:0]    in_data;
    logic                     pop;
    logic                     last_issue;
    logic                     issue;
    logic                     snoop_hit;
    logic [2:0]               occupancy;

    // A word returning from the RAM falls through to the output when the FIFO is empty.
    assign in_data    = snoop_hit_q ? snoop_data_q : read_data;
    assign fifo_empty = (fifo_count == 2'd0);
    assign out_valid  = !fifo_empty || inflight_q;
    assign out_data   = (fifo_empty && inflight_q) ? in_data : fifo_data;
    assign out_last   = out_valid && ((fifo_empty && inflight_q) ? inflight_last_q : fifo_last);
    assign pop        = out_valid && out_ready;

    // Slot freed by this cycle's pop is credited so a continuous stream never stalls.
    assign occupancy  = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign issue      = (state_q == RR_STATE_RUN) && (remaining_q != '0)
                        && (occupancy < 3'(RR_FIFO_DEPTH));
    assign last_issue = issue && (remaining_q == (address_width+1)'(1));
    assign snoop_hit  = issue && snoop_enable_write && snoop_write_enable
                        && (snoop_write_address == addr_q);

    assign enable_read  = issue;
    assign read_address = addr_q;
    assign busy         = (state_q == RR_STATE_RUN) || (state_q == RR_STATE_DRAIN);
    assign done         = (state_q == RR_STATE_DONE);

    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        unique case (state_q)
            RR_STATE_IDLE: begin
                if (start) begin
                    addr_d      = start_address;
                    remaining_d = length;
                    state_d     = (length == '0) ? RR_STATE_DONE : RR_STATE_RUN;
                end
            end
            RR_STATE_RUN: begin
                if (issue) begin
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                end
                if (last_issue) begin
                    state_d = RR_STATE_DRAIN;
                end
            end
            RR_STATE_DRAIN: begin
                if (pop && out_last) begin
                    state_d = RR_STATE_DONE;
                end
            end
            RR_STATE_DONE: state_d = RR_STATE_IDLE;
            default:       state_d = RR_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q         <= RR_STATE_IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            snoop_hit_q     <= 1'b0;
            snoop_data_q    <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= issue;
            inflight_last_q <= last_issue;
            snoop_hit_q     <= snoop_hit;
            if (snoop_hit) begin
                snoop_data_q <= snoop_write_data;
            end
        end
    end

    lm32_ram_reader_fifo #(
        .data_width (data_width)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_q && !(fifo_empty && out_ready)),
        .push_data_i (in_data),
        .push_last_i (inflight_last_q),
        .pop_i       (pop && !fifo_empty),
        .count_o     (fifo_count),
        .data_o      (fifo_data),
        .last_o      (fifo_last)
    );

endmodule

// File: tb/tb_lm32_ram_reader.sv
// Scoreboard bench for lm32_ram_reader against a 16-word RAM model with write-after-read ordering.
module tb_lm32_ram_reader;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int WORDS = 1 << AW;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_address = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, enable_read, out_valid, out_last;
    logic [AW-1:0] read_address;
    logic [DW-1:0] read_data = '0;
    logic          snoop_enable_write = 1'b0;
    logic          snoop_write_enable = 1'b0;
    logic [AW-1:0] snoop_write_address = '0;
    logic [DW-1:0] snoop_write_data = '0;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] mem [WORDS];
    logic [DW-1:0] exp_mem [WORDS];
    logic [DW:0]   exp_q [$];
    logic [AW-1:0] addr_log [$];
    int            issued = 0;
    int            accepted = 0;
    int            tick = 0;
    logic          hold_valid = 1'b0;
    logic [DW-1:0] hold_data = '0;
    bit            pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    lm32_ram_reader #(.data_width(DW), .address_width(AW)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .start               (start),
        .start_address       (start_address),
        .length              (length),
        .busy                (busy),
        .done                (done),
        .enable_read         (enable_read),
        .read_address        (read_address),
        .read_data           (read_data),
        .snoop_enable_write  (snoop_enable_write),
        .snoop_write_enable  (snoop_write_enable),
        .snoop_write_address (snoop_write_address),
        .snoop_write_data    (snoop_write_data),
        .out_valid           (out_valid),
        .out_data            (out_data),
        .out_last            (out_last),
        .out_ready           (out_ready)
    );

    always #5 clk_i = ~clk_i;

    // RAM model: 1-cycle read, garbage on read_data when no read was issued, old data on collision.
    always @(posedge clk_i) begin
        tick <= tick + 1;
        if (enable_read) read_data <= mem[read_address];
        else             read_data <= 32'hBAD0_0000 | 32'(tick[15:0]);
        if (snoop_enable_write && snoop_write_enable) mem[snoop_write_address] <= snoop_write_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, checks stall stability and outstanding reads.
    always @(negedge clk_i) begin
        if (rst_i) begin
            hold_valid = 1'b0;
        end else begin
            if (enable_read) begin
                addr_log.push_back(read_address);
                check("outstanding_le_2",
                      64'((issued + 1 - accepted - int'(out_valid && out_ready)) <= 2), 64'd1);
            end
            if (hold_valid && out_valid) check("stall_stable", 64'(out_data), 64'(hold_data));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e[DW-1:0]));
                    check("out_last", 64'(out_last), 64'(e[DW]));
                end
            end
            issued     = issued + int'(enable_read);
            accepted   = accepted + int'(out_valid && out_ready);
            hold_valid = out_valid && !out_ready;
            hold_data  = out_data;
        end
    end

    task automatic burst(input int sa, input int len, input bit toggle, input int snoop_cyc,
                         input int snoop_addr, input logic [DW-1:0] snoop_val, input int hit_idx,
                         input int exp_done, input int exp_first);
        int  cyc;
        int  done_cyc;
        int  first;
        bit  saw_er;
        bit  saw_busy;
        for (int i = 0; i < len; i++) begin
            logic [DW-1:0] d;
            d = (i == hit_idx) ? snoop_val : exp_mem[(sa + i) % WORDS];
            exp_q.push_back({(i == len - 1), d});
        end
        addr_log.delete();
        issued = 0;
        accepted = 0;
        done_cyc = -1;
        first = -1;
        saw_er = 0;
        saw_busy = 0;
        @(posedge clk_i); #1;
        start = 1'b1;
        start_address = AW'(sa);
        length = (AW+1)'(len);
        out_ready = toggle ? pat[0] : 1'b1;
        cyc = 1;
        @(posedge clk_i); #1;
        start = 1'b0;
        while (cyc < 300) begin
            out_ready = toggle ? pat[cyc % 6] : 1'b1;
            snoop_enable_write  = (cyc == snoop_cyc);
            snoop_write_enable  = (cyc == snoop_cyc);
            snoop_write_address = AW'(snoop_addr);
            snoop_write_data    = snoop_val;
            @(negedge clk_i);
            if (cyc == snoop_cyc && hit_idx >= 0) check("snoop_same_cycle_addr",
                64'({enable_read, read_address}), 64'({1'b1, AW'(snoop_addr)}));
            if (cyc == 1 && len > 0) check("busy_in_run", 64'(busy), 64'd1);
            if (enable_read) saw_er = 1;
            if (busy) saw_busy = 1;
            if (out_valid && first < 0) first = cyc;
            if (done) begin
                done_cyc = cyc;
                check("busy_at_done", 64'(busy), 64'd0);
                break;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        snoop_enable_write = 1'b0;
        snoop_write_enable = 1'b0;
        if (done_cyc < 0) check("done_timeout", 64'd0, 64'd1);
        if (exp_done >= 0) check("done_cycle", 64'(done_cyc), 64'(exp_done));
        if (exp_first >= 0) check("first_valid_cycle", 64'(first), 64'(exp_first));
        if (len == 0) begin
            check("len0_no_read", 64'(saw_er), 64'd0);
            check("len0_no_valid", 64'(first >= 0), 64'd0);
            check("len0_not_busy", 64'(saw_busy), 64'd0);
        end
        check("reads_issued", 64'(addr_log.size()), 64'(len));
        for (int i = 0; i < len && i < addr_log.size(); i++)
            check("read_address_seq", 64'(addr_log[i]), 64'((sa + i) % WORDS));
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("done_one_cycle", 64'(done), 64'd0);
        if (snoop_cyc >= 0) exp_mem[snoop_addr] = snoop_val;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = 32'h100 + 32'(i);
            exp_mem[i] = 32'h100 + 32'(i);
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_enable_read", 64'(enable_read), 64'd0);
        check("rst_read_address", 64'(read_address), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);

        burst(4, 4, 0, -1, 0, '0, -1, 6, 2);
        burst(0, 0, 0, -1, 0, '0, -1, 1, -1);
        burst(14, 4, 0, -1, 0, '0, -1, 6, 2);
        burst(14, 4, 1, -1, 0, '0, -1, -1, -1);
        burst(4, 4, 0, 3, 6, 32'hDEAD_BEEF, 2, 6, 2);
        burst(4, 4, 0, 4, 6, 32'hCAFE_F00D, -1, 6, 2);
        burst(5, 16, 0, -1, 0, '0, -1, 18, 2);

        // Reset in the third cycle of a length-8 burst while the consumer stalls.
        out_ready = 1'b0;
        @(posedge clk_i); #1;
        start = 1'b1;
        start_address = '0;
        length = (AW+1)'(8);
        @(posedge clk_i); #1;
        start = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_enable_read", 64'(enable_read), 64'd0);
        check("abort_read_address", 64'(read_address), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_last", 64'(out_last), 64'd0);
        check("abort_out_data", 64'(out_data), 64'd0);
        exp_q.delete();
        issued = 0;
        accepted = 0;
        saw_done = 0;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            if (done || out_valid) saw_done = 1;
        end
        check("abort_quiet", 64'(saw_done), 64'd0);
        burst(4, 4, 0, -1, 0, '0, -1, 6, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
